// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: PC source
// encodings, sequencer states and the register-match helper.
package pipeline_hazard_ctrl_pkg;

    // PC source select encodings seen by the PC input mux
    localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
    localparam logic [1:0] PC_SEL_BR    = 2'd1;
    localparam logic [1:0] PC_SEL_STACK = 2'd2;
    localparam logic [1:0] PC_SEL_VEC   = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        RUN            = 3'd0,
        RET_WAIT       = 3'd1,
        INT_DRAIN      = 3'd2,
        INT_PUSH_PC    = 3'd3,
        INT_PUSH_FLAGS = 3'd4,
        INT_VECTOR     = 3'd5
    } state_t;

    // True when the ID instruction actually reads src and src names dest
    function automatic logic reg_match(input logic uses,
                                       input logic [1:0] src,
                                       input logic [1:0] dest);
        return uses & (src == dest);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the datapath and the hazard controller.
// master is the datapath side, slave is the controller side.
interface pipeline_hazard_ctrl_if;

    // Pipeline status from the datapath
    logic       id_valid;
    logic [1:0] id_ra;
    logic [1:0] id_rb;
    logic       id_uses_ra;
    logic       id_uses_rb;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [1:0] ex_reg_dest;
    logic       ex_ret;
    logic       ex_rti;
    logic       branch_taken;
    logic       mem_data_access;
    logic       irq;

    // Flow controls back to the datapath
    logic       pc_write_en;
    logic [1:0] pc_sel;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       int_push_pc;
    logic       int_push_flags;
    logic       irq_ack;
    logic       int_masked;

    modport master (
        output id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb,
               ex_mem_read, ex_reg_write, ex_reg_dest, ex_ret, ex_rti,
               branch_taken, mem_data_access, irq,
        input  pc_write_en, pc_sel, if_id_stall, if_id_flush, id_ex_flush,
               int_push_pc, int_push_flags, irq_ack, int_masked
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb,
               ex_mem_read, ex_reg_write, ex_reg_dest, ex_ret, ex_rti,
               branch_taken, mem_data_access, irq,
        output pc_write_en, pc_sel, if_id_stall, if_id_flush, id_ex_flush,
               int_push_pc, int_push_flags, irq_ack, int_masked
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register
// a load currently in EX is about to write.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [1:0] i_id_ra,
    input  logic [1:0] i_id_rb,
    input  logic       i_id_uses_ra,
    input  logic       i_id_uses_rb,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_reg_write,
    input  logic [1:0] i_ex_reg_dest,
    output logic       o_load_use
);

    logic w_match_ra;
    logic w_match_rb;
    logic w_ex_is_load;

    // A load in EX only produces its value after MEM, so any ID reader must wait
    always_comb begin
        w_match_ra   = reg_match(i_id_uses_ra, i_id_ra, i_ex_reg_dest);
        w_match_rb   = reg_match(i_id_uses_rb, i_id_rb, i_ex_reg_dest);
        w_ex_is_load = i_ex_mem_read & i_ex_reg_write;
        o_load_use   = w_ex_is_load & i_id_valid & (w_match_ra | w_match_rb);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 8-bit 5-stage pipeline. Steers the PC
// and the IF/ID and ID/EX pipeline registers around load-use, branch,
// memory-port and return/interrupt hazards.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RET_LAT      = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] RET_LOAD   = CNT_W'(RET_LAT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_int_masked;
    logic             w_int_masked_nxt;
    logic             r_ret_rti;
    logic             w_ret_rti_nxt;
    logic             w_load_use;
    logic             w_cnt_zero;
    logic             w_irq_take;

    load_use_detect u_load_use (
        .i_id_valid     (hz.id_valid),
        .i_id_ra        (hz.id_ra),
        .i_id_rb        (hz.id_rb),
        .i_id_uses_ra   (hz.id_uses_ra),
        .i_id_uses_rb   (hz.id_uses_rb),
        .i_ex_mem_read  (hz.ex_mem_read),
        .i_ex_reg_write (hz.ex_reg_write),
        .i_ex_reg_dest  (hz.ex_reg_dest),
        .o_load_use     (w_load_use)
    );

    assign w_cnt_zero    = (r_cnt == '0);
    assign w_irq_take    = hz.irq & ~r_int_masked;
    assign hz.int_masked = r_int_masked;

    // State, wait counter, interrupt mask and RTI marker registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_int_masked <= 1'b0;
            r_ret_rti    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_int_masked <= w_int_masked_nxt;
            r_ret_rti    <= w_ret_rti_nxt;
        end
    end

    // Next-state logic; in RUN the hazard priority order decides which event starts a sequence
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_int_masked_nxt = r_int_masked;
        w_ret_rti_nxt    = r_ret_rti;
        case (r_state)
            RUN: begin
                if (hz.branch_taken) begin
                    w_state_nxt = RUN;
                end else if (hz.ex_ret) begin
                    w_state_nxt   = RET_WAIT;
                    w_cnt_nxt     = RET_LOAD;
                    w_ret_rti_nxt = hz.ex_rti;
                end else if (w_load_use || hz.mem_data_access) begin
                    w_state_nxt = RUN;
                end else if (w_irq_take) begin
                    w_state_nxt = INT_DRAIN;
                    w_cnt_nxt   = DRAIN_LOAD;
                end
            end
            RET_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = RUN;
                    if (r_ret_rti) begin
                        w_int_masked_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            INT_DRAIN: begin
                // A return reaching EX must complete first; the irq stays pending
                if (hz.ex_ret) begin
                    w_state_nxt   = RET_WAIT;
                    w_cnt_nxt     = RET_LOAD;
                    w_ret_rti_nxt = hz.ex_rti;
                end else if (w_cnt_zero) begin
                    w_state_nxt = INT_PUSH_PC;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            INT_PUSH_PC: begin
                w_state_nxt = INT_PUSH_FLAGS;
            end
            INT_PUSH_FLAGS: begin
                w_state_nxt = INT_VECTOR;
            end
            INT_VECTOR: begin
                w_state_nxt      = RUN;
                w_int_masked_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Flow-control outputs, combinational from state and current pipeline status
    always_comb begin
        hz.pc_write_en    = 1'b1;
        hz.pc_sel         = PC_SEL_SEQ;
        hz.if_id_stall    = 1'b0;
        hz.if_id_flush    = 1'b0;
        hz.id_ex_flush    = 1'b0;
        hz.int_push_pc    = 1'b0;
        hz.int_push_flags = 1'b0;
        hz.irq_ack        = 1'b0;
        case (r_state)
            RUN: begin
                if (hz.branch_taken) begin
                    hz.pc_sel      = PC_SEL_BR;
                    hz.if_id_flush = 1'b1;
                    hz.id_ex_flush = 1'b1;
                end else if (hz.ex_ret) begin
                    hz.pc_write_en = 1'b0;
                    hz.if_id_flush = 1'b1;
                    hz.id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    hz.pc_write_en = 1'b0;
                    hz.if_id_stall = 1'b1;
                    hz.id_ex_flush = 1'b1;
                end else if (hz.mem_data_access) begin
                    hz.pc_write_en = 1'b0;
                    hz.if_id_flush = 1'b1;
                end else if (w_irq_take) begin
                    hz.pc_write_en = 1'b0;
                    hz.if_id_flush = 1'b1;
                end
            end
            RET_WAIT: begin
                hz.pc_write_en = 1'b0;
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
                if (w_cnt_zero) begin
                    hz.pc_sel      = PC_SEL_STACK;
                    hz.pc_write_en = 1'b1;
                end
            end
            INT_DRAIN: begin
                hz.pc_write_en = 1'b0;
                hz.if_id_flush = 1'b1;
                if (hz.branch_taken) begin
                    hz.pc_sel      = PC_SEL_BR;
                    hz.pc_write_en = 1'b1;
                    hz.id_ex_flush = 1'b1;
                end else if (hz.ex_ret) begin
                    hz.id_ex_flush = 1'b1;
                end
            end
            INT_PUSH_PC: begin
                hz.int_push_pc = 1'b1;
                hz.pc_write_en = 1'b0;
                hz.if_id_flush = 1'b1;
            end
            INT_PUSH_FLAGS: begin
                hz.int_push_flags = 1'b1;
                hz.pc_write_en    = 1'b0;
                hz.if_id_flush    = 1'b1;
            end
            INT_VECTOR: begin
                hz.pc_sel      = PC_SEL_VEC;
                hz.pc_write_en = 1'b1;
                hz.if_id_flush = 1'b1;
                hz.irq_ack     = 1'b1;
            end
            default: begin
                hz.pc_write_en = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN
// vectors plus hand-written return, interrupt, masking and reset sequences.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_ctrl_if hif ();

    pipeline_hazard_ctrl #(
        .RET_LAT      (2),
        .DRAIN_CYCLES (3),
        .CNT_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       ura;
        logic       urb;
        logic       mr;
        logic       rw;
        logic [1:0] dest;
        logic       br;
        logic       mem;
        logic       expWe;
        logic [1:0] expSel;
        logic       expStall;
        logic       expIfFlush;
        logic       expExFlush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic v, logic [1:0] ra, logic [1:0] rb,
                                logic ura, logic urb, logic mr, logic rw,
                                logic [1:0] dest, logic br, logic mem,
                                logic we, logic [1:0] sel, logic st,
                                logic fi, logic fe);
        vec_t t;
        t.name = n; t.valid = v; t.ra = ra; t.rb = rb; t.ura = ura; t.urb = urb;
        t.mr = mr; t.rw = rw; t.dest = dest; t.br = br; t.mem = mem;
        t.expWe = we; t.expSel = sel; t.expStall = st;
        t.expIfFlush = fi; t.expExFlush = fe;
        return t;
    endfunction

    task automatic cmp(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", n, act, exp);
        end
    endtask

    task automatic clearInputs();
        hif.id_valid = 0; hif.id_ra = 0; hif.id_rb = 0;
        hif.id_uses_ra = 0; hif.id_uses_rb = 0;
        hif.ex_mem_read = 0; hif.ex_reg_write = 0; hif.ex_reg_dest = 0;
        hif.ex_ret = 0; hif.ex_rti = 0; hif.branch_taken = 0;
        hif.mem_data_access = 0; hif.irq = 0;
    endtask

    task automatic applyStimulus(vec_t v);
        clearInputs();
        hif.id_valid = v.valid; hif.id_ra = v.ra; hif.id_rb = v.rb;
        hif.id_uses_ra = v.ura; hif.id_uses_rb = v.urb;
        hif.ex_mem_read = v.mr; hif.ex_reg_write = v.rw; hif.ex_reg_dest = v.dest;
        hif.branch_taken = v.br; hif.mem_data_access = v.mem;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(string t, logic we, logic [1:0] sel, logic st,
                               logic fi, logic fe, logic pp, logic pf,
                               logic ack, logic m);
        #1;
        cmp({t, ".pc_write_en"}, int'(hif.pc_write_en), int'(we));
        cmp({t, ".pc_sel"}, int'(hif.pc_sel), int'(sel));
        cmp({t, ".if_id_stall"}, int'(hif.if_id_stall), int'(st));
        cmp({t, ".if_id_flush"}, int'(hif.if_id_flush), int'(fi));
        cmp({t, ".id_ex_flush"}, int'(hif.id_ex_flush), int'(fe));
        cmp({t, ".int_push_pc"}, int'(hif.int_push_pc), int'(pp));
        cmp({t, ".int_push_flags"}, int'(hif.int_push_flags), int'(pf));
        cmp({t, ".irq_ack"}, int'(hif.irq_ack), int'(ack));
        cmp({t, ".int_masked"}, int'(hif.int_masked), int'(m));
        cmp({t, ".stall_flush_excl"}, int'(hif.if_id_stall & hif.if_id_flush), 0);
    endtask

    initial begin
        //             name          v  ra rb ura urb mr rw dst br mem  we sel st fi fe
        vecs.push_back(mk("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("lu_ra",    1, 1, 0, 1, 0, 1, 1, 1, 0, 0,   0, 0, 1, 0, 1));
        vecs.push_back(mk("lu_rb",    1, 0, 2, 0, 1, 1, 1, 2, 0, 0,   0, 0, 1, 0, 1));
        vecs.push_back(mk("ra_unused",1, 1, 0, 0, 0, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("id_nop",   0, 1, 1, 1, 1, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("not_load", 1, 3, 0, 1, 0, 0, 1, 3, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("no_wb",    1, 3, 0, 1, 0, 1, 0, 3, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("dest_diff",1, 1, 2, 1, 1, 1, 1, 3, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk("br_lu",    1, 1, 0, 1, 0, 1, 1, 1, 1, 0,   1, 1, 0, 1, 1));
        vecs.push_back(mk("mem",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0));
        vecs.push_back(mk("lu_mem",   1, 2, 0, 1, 0, 1, 1, 2, 0, 1,   0, 0, 1, 0, 1));
        vecs.push_back(mk("br_mem",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   1, 1, 0, 1, 1));

        clearInputs();
        rst = 1'b1;
        #1;
        checkOutput("reset_asserted", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        checkOutput("reset_released", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single-cycle RUN vectors; none of them leaves RUN
        foreach (vecs[i]) begin
            nextCycle();
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].expWe, vecs[i].expSel, vecs[i].expStall,
                        vecs[i].expIfFlush, vecs[i].expExFlush, 0, 0, 0, 0);
        end

        // Load-use bubble lasts one cycle: next cycle ID/EX holds the bubble
        nextCycle();
        clearInputs();
        hif.id_valid = 1; hif.id_ra = 1; hif.id_uses_ra = 1;
        checkOutput("lu_after", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Two cycles of memory port busy
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            clearInputs();
            hif.mem_data_access = 1;
            checkOutput($sformatf("mem2_%0d", c), 0, 0, 0, 1, 0, 0, 0, 0, 0);
        end

        // Plain RET
        nextCycle(); clearInputs(); hif.ex_ret = 1;
        checkOutput("ret_start", 0, 0, 0, 1, 1, 0, 0, 0, 0);
        nextCycle(); clearInputs();
        checkOutput("ret_wait", 0, 0, 0, 1, 1, 0, 0, 0, 0);
        nextCycle();
        checkOutput("ret_pop", 1, 2, 0, 1, 1, 0, 0, 0, 0);
        nextCycle();
        checkOutput("ret_done", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // irq, then a RET reaches EX during drain and aborts it
        nextCycle(); hif.irq = 1;
        checkOutput("abort_take", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nextCycle(); hif.ex_ret = 1;
        checkOutput("abort_ret", 0, 0, 0, 1, 1, 0, 0, 0, 0);
        nextCycle(); hif.ex_ret = 0;
        checkOutput("abort_wait", 0, 0, 0, 1, 1, 0, 0, 0, 0);
        nextCycle();
        checkOutput("abort_pop", 1, 2, 0, 1, 1, 0, 0, 0, 0);
        // irq still pending: taken again back in RUN
        nextCycle();
        checkOutput("retake", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nextCycle(); hif.irq = 0;
        checkOutput("drain_a1", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nextCycle(); hif.branch_taken = 1;
        checkOutput("drain_branch", 1, 1, 0, 1, 1, 0, 0, 0, 0);
        nextCycle(); hif.branch_taken = 0;
        checkOutput("drain_a3", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("push_pc_a", 0, 0, 0, 1, 0, 1, 0, 0, 0);
        nextCycle();
        checkOutput("push_flags_a", 0, 0, 0, 1, 0, 0, 1, 0, 0);
        #2 rst = 1'b1;
        checkOutput("reset_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle(); rst = 1'b0;
        checkOutput("reset_after", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("reset_no_ack", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Full interrupt entry; irq dropped after drain starts
        nextCycle(); hif.irq = 1;
        checkOutput("irq_take", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nextCycle(); hif.irq = 0;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("drain_%0d", d), 0, 0, 0, 1, 0, 0, 0, 0, 0);
            nextCycle();
        end
        checkOutput("push_pc", 0, 0, 0, 1, 0, 1, 0, 0, 0);
        nextCycle();
        checkOutput("push_flags", 0, 0, 0, 1, 0, 0, 1, 0, 0);
        nextCycle();
        checkOutput("vector", 1, 3, 0, 1, 0, 0, 0, 1, 0);

        // Masked: a new irq is ignored
        nextCycle(); hif.irq = 1;
        checkOutput("masked_1", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        nextCycle();
        checkOutput("masked_2", 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Plain RET keeps the mask
        nextCycle(); hif.irq = 0; hif.ex_ret = 1;
        checkOutput("mret_start", 0, 0, 0, 1, 1, 0, 0, 0, 1);
        nextCycle(); hif.ex_ret = 0;
        checkOutput("mret_wait", 0, 0, 0, 1, 1, 0, 0, 0, 1);
        nextCycle();
        checkOutput("mret_pop", 1, 2, 0, 1, 1, 0, 0, 0, 1);
        nextCycle();
        checkOutput("mret_done", 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // RTI clears the mask once the return completes
        nextCycle(); hif.ex_ret = 1; hif.ex_rti = 1;
        checkOutput("rti_start", 0, 0, 0, 1, 1, 0, 0, 0, 1);
        nextCycle(); hif.ex_ret = 0; hif.ex_rti = 0;
        checkOutput("rti_wait", 0, 0, 0, 1, 1, 0, 0, 0, 1);
        nextCycle();
        checkOutput("rti_pop", 1, 2, 0, 1, 1, 0, 0, 0, 1);
        nextCycle();
        checkOutput("rti_done", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Interrupts accepted again
        nextCycle(); hif.irq = 1;
        checkOutput("irq_again", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nextCycle(); clearInputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 8-bit 5-stage pipeline.
- Drives the PC write enable and PC source select, plus the stall/flush controls of the IF/ID register and the flush control of the ID/EX register.
- Resolves four hazard classes:
  - load-use data hazards;
  - taken-branch control hazards;
  - single-port memory structural conflicts (data access in MEM versus instruction fetch);
  - multi-cycle RET/RTI returns and interrupt entry.

Parameters:
- RET_LAT, 2, cycles from a RET/RTI leaving EX until the popped PC is valid on the stack data bus (1..7).
- DRAIN_CYCLES, 3, cycles with fetch suppressed before interrupt entry, letting in-flight instructions retire (1..7).
- CNT_W, 3, width of the shared wait counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  IF/ID holds a real (non-NOP) instruction
- id_ra  in  2  source register A of the instruction in ID
- id_rb  in  2  source register B of the instruction in ID
- id_uses_ra  in  1  instruction in ID reads ra
- id_uses_rb  in  1  instruction in ID reads rb
- ex_mem_read  in  1  mem_read of ID/EX output
- ex_reg_write  in  1  reg_write_enable of ID/EX output
- ex_reg_dest  in  2  reg_dest of ID/EX output
- ex_ret  in  1  is_ret or is_rti of ID/EX output
- ex_rti  in  1  is_rti of ID/EX output
- branch_taken  in  1  EX-stage branch/call resolved taken
- mem_data_access  in  1  EX/MEM mem_read or mem_write (memory port busy this cycle)
- irq  in  1  level interrupt request
- pc_write_en  out  1  PC register load enable
- pc_sel  out  2  PC source: 0 PC+1, 1 branch target, 2 stack data, 3 interrupt vector
- if_id_stall  out  1  IF/ID hold
- if_id_flush  out  1  IF/ID load NOP
- id_ex_flush  out  1  ID/EX load bubble
- int_push_pc  out  1  datapath pushes PC, SP decrements
- int_push_flags  out  1  datapath pushes flags, SP decrements
- irq_ack  out  1  one-cycle acknowledge
- int_masked  out  1  interrupts blocked; high from irq_ack until RTI completes

Behaviour:
- Defaults apply every cycle unless overridden: pc_write_en=1, pc_sel=0, all other outputs 0.
- Reset (async): state=RUN, counter=0, int_masked=0. All control outputs therefore take their default values.
- pc_write_en and the other flow outputs are combinational from state and inputs. State, counter and int_masked are registered.
- load_use = ex_mem_read & ex_reg_write & id_valid & ((id_uses_ra & id_ra==ex_reg_dest) | (id_uses_rb & id_rb==ex_reg_dest)).
- RUN state; the first matching item wins:
  1. branch_taken: pc_sel=1, if_id_flush=1, id_ex_flush=1.
  2. ex_ret: pc_write_en=0, if_id_flush=1, id_ex_flush=1. Load counter=RET_LAT-1, go to RET_WAIT.
  3. load_use: pc_write_en=0, if_id_stall=1, id_ex_flush=1. This inserts exactly one bubble.
  4. mem_data_access: pc_write_en=0, if_id_flush=1. This is a fetch bubble; ID still advances.
  5. irq & ~int_masked: pc_write_en=0, if_id_flush=1. Load counter=DRAIN_CYCLES-1, go to INT_DRAIN.
- Combination rule: if_id_stall and if_id_flush are never both 1.
- RET_WAIT:
  - Each cycle: pc_write_en=0, if_id_flush=1, id_ex_flush=1, counter decrements.
  - At counter==0: pc_sel=2, pc_write_en=1, return to RUN.
  - If the return was an RTI (ex_rti latched when RET_WAIT was entered), clear int_masked on that same cycle.
- INT_DRAIN:
  - Each cycle: pc_write_en=0, if_id_flush=1, counter decrements.
  - branch_taken during drain: pc_sel=1, pc_write_en=1, id_ex_flush=1; drain continues.
  - ex_ret during drain: abort to RET_WAIT (counter=RET_LAT-1). irq remains pending.
  - At counter==0 with no abort: go to INT_PUSH_PC.
- INT_PUSH_PC: int_push_pc=1, pc_write_en=0, if_id_flush=1; next state INT_PUSH_FLAGS.
- INT_PUSH_FLAGS: int_push_flags=1, pc_write_en=0, if_id_flush=1; next state INT_VECTOR.
- INT_VECTOR: pc_sel=3, pc_write_en=1, if_id_flush=1, irq_ack=1. Set int_masked, go to RUN.
- irq deasserting after INT_DRAIN is entered does not cancel the entry sequence.
- Reset asserted mid-sequence returns immediately to RUN with int_masked=0.

Decomposition:
- Shared package holds:
  - pc_sel encodings (PC_SEL_SEQ/BR/STACK/VEC);
  - state encoding (RUN, RET_WAIT, INT_DRAIN, INT_PUSH_PC, INT_PUSH_FLAGS, INT_VECTOR).
- One natural sub-module: load_use_detect, a combinational comparator producing load_use.

Test Plan:
- LDR R1 in EX (ex_mem_read=1, ex_reg_write=1, dest=1) with ID using ra=1 -> one cycle of pc_write_en=0, if_id_stall=1, id_ex_flush=1; next cycle all defaults.
- branch_taken=1 asserted together with load_use=1 -> pc_sel=1, both flushes=1, if_id_stall=0.
- ex_ret=1 with RET_LAT=2 -> 2 cycles of pc_write_en=0 and flushes, then one cycle with pc_sel=2, pc_write_en=1.
- irq=1 in RUN, DRAIN_CYCLES=3 -> drain cycles, then int_push_pc for 1 cycle, int_push_flags for 1 cycle, then pc_sel=3 with irq_ack=1; int_masked=1 afterwards. A second irq is then ignored until an RTI completes, after which int_masked=0.
- mem_data_access=1 for 2 cycles -> pc_write_en=0 and if_id_flush=1 for 2 cycles, id_ex_flush=0.
- rst pulsed during INT_PUSH_FLAGS -> immediate RUN, int_masked=0, no irq_ack.
